// File: rtl/ghash_stream.sv
// ghash_stream: streaming GHASH accumulator for AES-GCM.
// Y_i = (Y_{i-1} ^ X_i) * H mod POLYNOMIAL, Y_0 = 0, multiplied iteratively
// over GFM_CYCLES cycles (GFM_BITS/GFM_CYCLES unrolled steps per cycle).
// Optional build macro: GHASH_BITREFLECT_EN -- bit-reverse h_in, s_data and
// m_data at the boundary (NIST GCM bit order, port MSB = x^0).
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high; valid, once raised, holds its data stable until
// that edge. A block presented together with h_load is not taken (h_load wins).
module ghash_stream #(
    parameter int                GFM_BITS   = 128,
    parameter int                GFM_CYCLES = 8,
    parameter logic [GFM_BITS:0] POLYNOMIAL = 129'h1_0000_0000_0000_0000_0000_0000_0000_0087
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                h_load,
    input  logic [GFM_BITS-1:0] h_in,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [GFM_BITS-1:0] s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [GFM_BITS-1:0] m_data,
    output logic                busy
);

    localparam int STEPS = GFM_BITS / GFM_CYCLES;
    localparam int RW    = (GFM_CYCLES > 1) ? $clog2(GFM_CYCLES) : 1;
    // The x^n term always cancels against the shifted-out bit, so only the
    // low n bits of the polynomial take part in the reduction.
    localparam logic [GFM_BITS-1:0] POLY_LOW = POLYNOMIAL[GFM_BITS-1:0];

    typedef enum logic [1:0] {IDLE, MULT, OUT} state_t;

    state_t                state, state_next;
    logic [GFM_BITS-1:0]   h_q, y_q, a_q, b_q, acc_q;
    logic [GFM_BITS-1:0]   a_next, b_next, acc_next;
    logic [GFM_BITS-1:0]   h_int, x_int;
    logic [RW-1:0]         round_q;
    logic                  last_q, s_ready_q;
    logic                  take_block, last_round;

`ifdef GHASH_BITREFLECT_EN
    // Boundary bit reversal: port bit n-1 maps to internal coefficient x^0.
    always_comb begin
        h_int  = '0;
        x_int  = '0;
        m_data = '0;
        for (int i = 0; i < GFM_BITS; i++) begin
            h_int[i]  = h_in[GFM_BITS-1-i];
            x_int[i]  = s_data[GFM_BITS-1-i];
            m_data[i] = y_q[GFM_BITS-1-i];
        end
    end
`else
    assign h_int  = h_in;
    assign x_int  = s_data;
    assign m_data = y_q;
`endif

    assign take_block = (state == IDLE) && s_valid && s_ready_q && !h_load;
    assign last_round = (round_q == RW'(GFM_CYCLES - 1));
    assign s_ready    = s_ready_q;
    assign m_valid    = (state == OUT);
    assign busy       = (state != IDLE);

    // One group of shift-and-add multiply steps, unrolled.
    always_comb begin
        a_next   = a_q;
        b_next   = b_q;
        acc_next = acc_q;
        for (int i = 0; i < STEPS; i++) begin
            if (b_next[0]) acc_next = acc_next ^ a_next;
            a_next = {a_next[GFM_BITS-2:0], 1'b0} ^ (a_next[GFM_BITS-1] ? POLY_LOW : '0);
            b_next = b_next >> 1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take_block) state_next = MULT;
            MULT: if (last_round) state_next = last_q ? OUT : IDLE;
            OUT:  if (m_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Registered s_ready: high whenever the next cycle is IDLE with no key load.
    always_ff @(posedge clk) begin
        if (reset) s_ready_q <= 1'b0;
        else       s_ready_q <= (state_next == IDLE) && !h_load;
    end

    // Key, accumulator and multiplier datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (h_load) begin
                        h_q <= h_int;
                        y_q <= '0;
                    end else if (take_block) begin
                        a_q     <= y_q ^ x_int;
                        b_q     <= h_q;
                        acc_q   <= '0;
                        round_q <= '0;
                        last_q  <= s_last;
                    end
                end
                MULT: begin
                    a_q     <= a_next;
                    b_q     <= b_next;
                    acc_q   <= acc_next;
                    round_q <= round_q + 1'b1;
                    if (last_round) y_q <= acc_next;
                end
                OUT: begin
                    if (m_ready) y_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_stream.sv
// Directed testbench for ghash_stream (default parameters: 128 bits, 8 cycles).
module tb_ghash_stream;

    localparam int N  = 128;
    localparam int GC = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         h_load;
    logic [N-1:0] h_in;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    ghash_stream dut (
        .clk(clk), .reset(reset), .h_load(h_load), .h_in(h_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Maps an internal polynomial value to its port encoding.
    function automatic logic [N-1:0] pv(input logic [N-1:0] v);
        logic [N-1:0] r;
`ifdef GHASH_BITREFLECT_EN
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
`else
        r = v;
`endif
        return r;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [N-1:0] h);
        h_load = 1'b1;
        h_in   = h;
        step();
        h_load = 1'b0;
    endtask

    // Waits (bounded) for s_ready then transfers one block; returns after the accepting edge.
    task automatic send_block(input logic [N-1:0] d, input logic last, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        if (!s_ready) begin
            timed_out = 1'b1;
        end else begin
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last;
            step();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_m_valid(output bit timed_out);
        int n = 0;
        while (!m_valid && n < 40) begin
            step();
            n++;
        end
        timed_out = !m_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_tests++;
        if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        step();
        n_tests++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
    endtask

    // H=1: result equals the block; checks latency and s_ready low during the multiply.
    task automatic test_identity();
        bit to;
        logic [N-1:0] x = 128'h0123456789ABCDEF0011223344556677;
        load_key(pv(128'd1));
        send_block(pv(x), 1'b1, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL ident_accept_timeout got=%b exp=0", to); end
        for (int k = 1; k <= GC; k++) begin
            n_tests++;
            if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ident_mult_cycle%0d s_ready=%b m_valid=%b busy=%b exp 0 0 1", k, s_ready, m_valid, busy);
            end
            step();
        end
        n_tests++;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ident_m_valid_latency got=%b exp=1", m_valid); end
        n_tests++;
        if (m_data !== pv(x)) begin n_fail++; $display("FAIL ident_m_data got=%h exp=%h", m_data, pv(x)); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ident_m_valid_drop got=%b exp=0", m_valid); end
    endtask

    // H=x, X=x^127: product x^128 reduces to 0x87.
    task automatic test_reduction();
        bit to;
        load_key(pv(128'd2));
        send_block(pv(128'd1 << 127), 1'b1, to);
        wait_m_valid(to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL reduce_timeout got=%b exp=0", to); end
        n_tests++;
        if (m_data !== pv(128'h87)) begin n_fail++; $display("FAIL reduce_m_data got=%h exp=%h", m_data, pv(128'h87)); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    // Two-block message: Y1 = 1*x = 2, Y2 = (2^1)*x = 6.
    task automatic test_two_blocks();
        bit to;
        load_key(pv(128'd2));
        send_block(pv(128'd1), 1'b0, to);
        for (int k = 1; k <= GC; k++) begin
            n_tests++;
            if (s_ready !== 1'b0) begin n_fail++; $display("FAIL two_blk1_s_ready_c%0d got=%b exp=0", k, s_ready); end
            step();
        end
        n_tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL two_blk1_done s_ready=%b m_valid=%b exp 1 0", s_ready, m_valid);
        end
        send_block(pv(128'd1), 1'b1, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL two_blk2_timeout got=%b exp=0", to); end
        for (int k = 1; k <= GC; k++) begin
            n_tests++;
            if (s_ready !== 1'b0) begin n_fail++; $display("FAIL two_blk2_s_ready_c%0d got=%b exp=0", k, s_ready); end
            step();
        end
        n_tests++;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL two_m_valid got=%b exp=1", m_valid); end
        n_tests++;
        if (m_data !== pv(128'd6)) begin n_fail++; $display("FAIL two_m_data got=%h exp=%h", m_data, pv(128'd6)); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    // Output held under backpressure; h_load in OUT ignored; old key reused.
    task automatic test_hold();
        bit to;
        load_key(pv(128'd3));
        send_block(pv(128'd5), 1'b1, to);
        wait_m_valid(to);
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== pv(128'hF)) begin
                n_fail++;
                $display("FAIL hold_c%0d m_valid=%b m_data=%h exp 1 %h", k, m_valid, m_data, pv(128'hF));
            end
            step();
        end
        h_load = 1'b1;
        h_in   = pv(128'd7);
        step();
        h_load = 1'b0;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== pv(128'hF)) begin
            n_fail++;
            $display("FAIL hold_hload m_valid=%b m_data=%h exp 1 %h", m_valid, m_data, pv(128'hF));
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drop got=%b exp=0", m_valid); end
        send_block(pv(128'd5), 1'b1, to);
        wait_m_valid(to);
        n_tests++;
        if (to !== 1'b0 || m_data !== pv(128'hF)) begin
            n_fail++;
            $display("FAIL hold_old_key timeout=%b m_data=%h exp 0 %h", to, m_data, pv(128'hF));
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    // Reset in the middle of a multiply aborts it; next message sees no stale state.
    task automatic test_reset_mid();
        bit to;
        load_key(pv(128'd2));
        send_block(pv(128'd1), 1'b1, to);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b m_valid=%b s_ready=%b m_data=%h exp 0 0 0 0", busy, m_valid, s_ready, m_data);
        end
        reset = 1'b0;
        step();
        load_key(pv(128'd1));
        send_block(pv(128'd5), 1'b1, to);
        wait_m_valid(to);
        n_tests++;
        if (to !== 1'b0 || m_data !== pv(128'd5)) begin
            n_fail++;
            $display("FAIL rst_mid_result timeout=%b m_data=%h exp 0 %h", to, m_data, pv(128'd5));
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    // m_ready high before m_valid: OUT lasts one cycle and Y is cleared for the next message.
    task automatic test_back_to_back();
        bit to;
        load_key(pv(128'd2));
        m_ready = 1'b1;
        for (int msg = 0; msg < 2; msg++) begin
            send_block(pv(128'd1), 1'b1, to);
            repeat (GC) step();
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== pv(128'd2)) begin
                n_fail++;
                $display("FAIL b2b_msg%0d m_valid=%b m_data=%h exp 1 %h", msg, m_valid, m_data, pv(128'd2));
            end
            step();
            n_tests++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_out_len%0d m_valid=%b busy=%b exp 0 0", msg, m_valid, busy);
            end
        end
        m_ready = 1'b0;
    endtask

`ifdef GHASH_BITREFLECT_EN
    // NIST bit order on raw port values: 0x80..0 is 1, and x^127 * x gives the GCM R constant.
    task automatic test_bitreflect();
        bit to;
        logic [N-1:0] x = 128'h0123456789ABCDEF0011223344556677;
        load_key(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send_block(x, 1'b1, to);
        wait_m_valid(to);
        n_tests++;
        if (to !== 1'b0 || m_data !== x) begin
            n_fail++;
            $display("FAIL reflect_ident timeout=%b m_data=%h exp 0 %h", to, m_data, x);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        load_key(128'h4000_0000_0000_0000_0000_0000_0000_0000);
        send_block(128'd1, 1'b1, to);
        wait_m_valid(to);
        n_tests++;
        if (to !== 1'b0 || m_data !== 128'hE100_0000_0000_0000_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL reflect_r timeout=%b m_data=%h exp 0 e1000000000000000000000000000000", to, m_data);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask
`endif

    initial begin
        reset   = 1'b1;
        h_load  = 1'b0;
        h_in    = '0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_identity();
        test_reduction();
        test_two_blocks();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef GHASH_BITREFLECT_EN
        test_bitreflect();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
